// File: rtl/data_ram_ws_pkg.sv
// ============================================================================
// data_ram_ws_pkg : shared FSM encoding, handshake levels and range helper
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package data_ram_ws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam int   CNT_W        = 3;

  // Any address bit above the word-index field marks the access as out of range.
  function automatic logic addr_in_range(input logic [31:0] addr, input int depth_log2);
    return (addr >> (depth_log2 + 2)) == 32'd0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_ws_if.sv
// ============================================================================
// data_ram_ws_if : request/acknowledge bus between MEM stage and data RAM
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface data_ram_ws_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                    ce;
  logic                    we;
  logic [31:0]             addr;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [DATA_WIDTH-1:0]   data_i;
  logic [DATA_WIDTH-1:0]   data_o;
  logic                    ack;
  logic                    err;
  logic                    busy;

  modport master (
    output ce, we, addr, sel, data_i,
    input  data_o, ack, err, busy
  );

  modport slave (
    input  ce, we, addr, sel, data_i,
    output data_o, ack, err, busy
  );

endinterface

`default_nettype wire

// File: rtl/data_ram_ws_ram_byte_lane.sv
// ============================================================================
// ram_byte_lane : one 8-bit lane, sync write, async read plus fixed debug read
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ram_byte_lane #(
  parameter int DEPTH_LOG2 = 10,
  parameter int DBG_INDEX  = 0
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [7:0]            wdata_i,
  output logic [7:0]            rdata_o,
  output logic [7:0]            dbg_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] DBG_ADDR = DEPTH_LOG2'(DBG_INDEX);

  logic [7:0] mem_q [DEPTH];

  // Contents are deliberately not reset; only the control path is.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];
  assign dbg_o   = mem_q[DBG_ADDR];

endmodule

`default_nettype wire

// File: rtl/data_ram_ws.sv
// ============================================================================
// data_ram_ws : wait-state byte-lane data memory with req/ack handshake
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module data_ram_ws
  import data_ram_ws_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2,
  parameter int DBG_INDEX   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  data_ram_ws_if.slave          bus,
  output logic [DATA_WIDTH-1:0] dbg_word_o
);

  localparam int LANES = DATA_WIDTH / 8;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    we_q;
  logic [31:0]             addr_q;
  logic [LANES-1:0]        sel_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    ack_q;
  logic                    err_q;

  logic                    accept;
  logic                    access;
  logic                    in_range;
  logic                    lane_wr;
  logic [DEPTH_LOG2-1:0]   widx;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    unused_addr_lsb;

  assign accept          = (state_q == ST_IDLE) && (bus.ce == CHIP_ENABLE);
  assign access          = (state_q == ST_WAIT) && (cnt_q == '0);
  assign in_range        = addr_in_range(addr_q, DEPTH_LOG2);
  assign lane_wr         = access && (we_q == WRITE_ENABLE) && in_range;
  assign widx            = addr_q[DEPTH_LOG2+1:2];
  assign unused_addr_lsb = ^addr_q[1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(WAIT_STATES);
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.we;
        addr_q  <= bus.addr;
        sel_q   <= bus.sel;
        wdata_q <= bus.data_i;
      end
      if (access) begin
        ack_q <= 1'b1;
        err_q <= !in_range;
        // Out-of-range reads and writes both clear data_o; in-range writes leave it.
        if (!in_range) begin
          data_q <= '0;
        end else if (we_q != WRITE_ENABLE) begin
          data_q <= rd_word;
        end
      end else if (state_q == ST_DONE) begin
        ack_q <= 1'b0;
        err_q <= 1'b0;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    ram_byte_lane #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .DBG_INDEX  (DBG_INDEX)
    ) u_lane (
      .clk     (clk),
      .we_i    (lane_wr && sel_q[l]),
      .addr_i  (widx),
      .wdata_i (wdata_q[8*l +: 8]),
      .rdata_o (rd_word[8*l +: 8]),
      .dbg_o   (dbg_word_o[8*l +: 8])
    );
  end

  assign bus.data_o = data_q;
  assign bus.ack    = ack_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q != ST_IDLE);

endmodule

`default_nettype wire
